// File: rtl/tick_divider_pkg.sv
// Shared constants and elaboration-time helpers for the tick divider and the display blocks.
// The optional TICK_DIVIDER_SYNC_EN build adds an external phase-align input on the top level.
package tick_divider_pkg;

    localparam int DEF_CLOCK_HZ  = 32'sd100_000_000;
    localparam int DEF_TICK_HZ   = 32'sd2;
    localparam int DEF_MOD_COUNT = 32'sd60;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v >>> 1;
        end
        return result;
    endfunction

    // A divisor below one cycle per tick is meaningless, so clamp to 1.
    function automatic int default_div(input int clock_hz, input int tick_hz);
        int d;
        if (tick_hz < 32'sd1) begin
            d = 32'sd1;
        end else begin
            d = clock_hz / tick_hz;
        end
        if (d < 32'sd1) begin
            d = 32'sd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/tick_divider_prescaler.sv
// Reloadable prescaler: holds the divisor, counts 0..div-1 and emits a registered one-cycle tick.
// tick_next is the combinational "tick lands next cycle" flag used by the top to update in step.
module tick_prescaler
    import tick_divider_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_load,
    output logic             tick_next,
    output logic             tick
);

    logic [CNT_W-1:0] prescale_r;
    logic [CNT_W-1:0] div_r;
    logic             tick_r;

    // Terminal count while running; a load or clear in the same cycle suppresses the tick.
    always_comb begin
        tick_next = 1'b0;
        if (enable && !div_load && !clear && (prescale_r == (div_r - CNT_W'(1)))) begin
            tick_next = 1'b1;
        end else begin
            tick_next = 1'b0;
        end
    end

    // Prescale counter and divisor register; priority reset > clear > load > count > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_r <= {CNT_W{1'b0}};
            div_r      <= CNT_W'(DEFAULT_DIV);
            tick_r     <= 1'b0;
        end else if (clear) begin
            prescale_r <= {CNT_W{1'b0}};
            tick_r     <= 1'b0;
        end else if (div_load) begin
            prescale_r <= {CNT_W{1'b0}};
            tick_r     <= 1'b0;
            if (div_value != {CNT_W{1'b0}}) begin
                div_r <= div_value;
            end
        end else if (tick_next) begin
            prescale_r <= {CNT_W{1'b0}};
            tick_r     <= 1'b1;
        end else if (enable) begin
            prescale_r <= prescale_r + CNT_W'(1);
            tick_r     <= 1'b0;
        end else begin
            tick_r     <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/tick_divider.sv
// Tick divider top: prescaled tick, 50% square wave, modulo tick counter and wrap flag.
// Define TICK_DIVIDER_SYNC_EN to add syncIn, which phase-aligns everything to an external PPS.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int CLOCK_HZ  = DEF_CLOCK_HZ,
    parameter int TICK_HZ   = DEF_TICK_HZ,
    parameter int MOD_COUNT = DEF_MOD_COUNT,
    parameter int CNT_W     = clog2(default_div(CLOCK_HZ, TICK_HZ) + 32'sd1),
    parameter int MOD_W     = clog2(MOD_COUNT)
) (
    input  logic             cmosClock,
    input  logic             reset,
`ifdef TICK_DIVIDER_SYNC_EN
    input  logic             syncIn,
`endif
    input  logic             enable,
    input  logic [CNT_W-1:0] divValue,
    input  logic             divLoad,
    output logic             tickPulse,
    output logic             clockOut,
    output logic [MOD_W-1:0] count,
    output logic             wrapPulse
);

    localparam int DEFAULT_DIV = default_div(CLOCK_HZ, TICK_HZ);
    localparam logic [MOD_W-1:0] LAST_COUNT = MOD_W'(MOD_COUNT - 32'sd1);

    logic             sync_s;
    logic             tick_next_s;
    logic             clock_r;
    logic [MOD_W-1:0] count_r;
    logic             wrap_r;

`ifdef TICK_DIVIDER_SYNC_EN
    assign sync_s = syncIn;
`else
    assign sync_s = 1'b0;
`endif

    tick_prescaler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk       (cmosClock),
        .reset     (reset),
        .clear     (sync_s),
        .enable    (enable),
        .div_value (divValue),
        .div_load  (divLoad),
        .tick_next (tick_next_s),
        .tick      (tickPulse)
    );

    // Square wave, modulo counter and wrap flag advance in the same cycle the tick appears.
    always_ff @(posedge cmosClock) begin
        if (reset || sync_s) begin
            clock_r <= 1'b0;
            count_r <= {MOD_W{1'b0}};
            wrap_r  <= 1'b0;
        end else if (tick_next_s) begin
            clock_r <= ~clock_r;
            if (count_r == LAST_COUNT) begin
                count_r <= {MOD_W{1'b0}};
                wrap_r  <= 1'b1;
            end else begin
                count_r <= count_r + MOD_W'(1);
                wrap_r  <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign clockOut  = clock_r;
    assign count     = count_r;
    assign wrapPulse = wrap_r;

endmodule
